// File: rtl/apb4_slave_regbank.sv
// APB4 completer register bank: byte-strobed RW registers, hardware-fed
// read-only registers, configurable wait states, relocatable base address,
// and PSLVERR for misaligned, out-of-range and read-only-write accesses.

// One RW register word with per-byte write enables.
module apb4_regbank_word #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] strb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   q
);
    // Update only the byte lanes whose strobe is set.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            q <= '0;
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++)
                if (strb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end
endmodule

module apb4_slave_regbank #(
    parameter int                      DATA_WIDTH  = 32,
    parameter int                      ADDR_WIDTH  = 32,
    parameter int                      REG_COUNT   = 8,
    parameter int                      WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = '0,
    parameter logic [REG_COUNT-1:0]    RO_MASK     = '0
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic [ADDR_WIDTH-1:0]            PADDR,
    input  logic                             PSEL,
    input  logic                             PENABLE,
    input  logic                             PWRITE,
    input  logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [DATA_WIDTH/8-1:0]          PSTRB,
    output logic [DATA_WIDTH-1:0]            PRDATA,
    output logic                             PREADY,
    output logic                             PSLVERR,
    input  logic [REG_COUNT*DATA_WIDTH-1:0]  hw_status,
    output logic [REG_COUNT*DATA_WIDTH-1:0]  reg_out,
    output logic [REG_COUNT-1:0]             wr_pulse
);
    localparam int NB = DATA_WIDTH/8;
    localparam int AL = $clog2(NB);
    localparam int IW = $clog2(REG_COUNT);
    localparam logic [ADDR_WIDTH:0] SPAN  = (ADDR_WIDTH+1)'(REG_COUNT*NB);
    localparam logic [3:0]          WLAST = 4'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t     state, state_nxt;
    logic [3:0] wcnt, wcnt_nxt;

    logic [ADDR_WIDTH-1:0]                off;
    logic [IW-1:0]                        idx;
    logic                                 misalign, in_range, ro_hit, err;
    logic                                 complete, commit;
    logic [REG_COUNT-1:0]                 sel;
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0]                rd_word;

    // Decode: offset wraps modulo 2^ADDR_WIDTH, so addresses below the base
    // land far out of range and error out through the same comparison.
    assign off      = PADDR - BASE_ADDR;
    assign idx      = off[AL +: IW];
    assign misalign = |off[AL-1:0];
    assign in_range = {1'b0, off} < SPAN;
    assign ro_hit   = |(sel & RO_MASK);
    assign err      = misalign | ~in_range | (PWRITE & ro_hit);
    assign complete = (state == ACCESS) && PSEL && (wcnt == WLAST);
    assign commit   = complete & PWRITE & ~err;

    assign PREADY   = complete;
    assign PSLVERR  = complete & err;
    assign PRDATA   = (complete & ~err & ~PWRITE) ? rd_word : '0;
    assign reg_out  = q;

    // One-hot register select and read mux (RO slots return hw_status).
    always_comb begin
        sel     = '0;
        rd_word = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            sel[i] = in_range && (idx == IW'(i));
            if (sel[i])
                rd_word = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : q[i];
        end
    end

    // hw_status slices behind RW registers are intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^hw_status;

    for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign q[i] = '0;
        end else begin : g_rw
            apb4_regbank_word #(.DATA_WIDTH(DATA_WIDTH)) u_word (
                .PCLK    (PCLK),
                .PRESETn (PRESETn),
                .we      (commit & sel[i]),
                .strb    (PSTRB),
                .wdata   (PWDATA),
                .q       (q[i])
            );
        end
    end

    // State, wait counter and the registered per-register write pulse.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            wcnt     <= '0;
            wr_pulse <= '0;
        end else begin
            state    <= state_nxt;
            wcnt     <= wcnt_nxt;
            wr_pulse <= commit ? sel : '0;
        end
    end

    // Next state: setup -> ACCESS, count wait states, abort on PSEL drop.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_nxt = ACCESS;
                    wcnt_nxt  = '0;
                end
            end
            ACCESS: begin
                if (!PSEL)              state_nxt = IDLE;
                else if (wcnt < WLAST)  wcnt_nxt  = wcnt + 4'd1;
                else                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/apb4_slave_regbank.md
Name: apb4_slave_regbank

Overview:
Parametrised APB4 completer register bank, next generation of the team's APB slave FSM. Adds byte strobes, configurable wait states, read-only status registers fed from hardware, a relocatable base address, and error signalling for misaligned, out-of-range and RO-write accesses. Sits on the peripheral APB segment behind the bridge and exports register contents to the block logic.

Parameters:
DATA_WIDTH, 32, data bus width; 32 or 64 only.
ADDR_WIDTH, 32, PADDR width.
REG_COUNT, 8, number of word registers; 2..64.
WAIT_STATES, 0, extra access-phase cycles before PREADY; 0..15.
BASE_ADDR, 0, byte address of register 0; must be aligned to DATA_WIDTH/8.
RO_MASK, 0, REG_COUNT-bit mask; bit i=1 makes register i read-only, sourced from hw_status.

Ports:
PCLK  in  1  APB clock; all logic on rising edge.
PRESETn  in  1  asynchronous active-low reset.
PADDR  in  ADDR_WIDTH  byte address.
PSEL  in  1  select.
PENABLE  in  1  access phase.
PWRITE  in  1  1=write, 0=read.
PWDATA  in  DATA_WIDTH  write data.
PSTRB  in  DATA_WIDTH/8  write byte lanes.
PRDATA  out  DATA_WIDTH  read data.
PREADY  out  1  transfer completes this cycle.
PSLVERR  out  1  transfer error; valid only with PREADY.
hw_status  in  REG_COUNT*DATA_WIDTH  RO register sources; slice i for register i.
reg_out  out  REG_COUNT*DATA_WIDTH  current RW register contents; slice i = register i.
wr_pulse  out  REG_COUNT  one-cycle pulse per register on committed write.

Behaviour:
- Reset (asynchronous, PRESETn=0): state IDLE, wait counter 0, all RW registers 0, reg_out 0, wr_pulse 0. PREADY, PSLVERR and PRDATA are 0 during and after reset until a transfer completes.
- FSM states: IDLE and ACCESS.
  - IDLE: PSEL=1 and PENABLE=0 (setup cycle) -> ACCESS with wcnt=0. PENABLE=1 without a prior setup is ignored; stay IDLE.
  - ACCESS: if wcnt<WAIT_STATES, wcnt++ and PREADY=0. If wcnt==WAIT_STATES, PREADY=1 combinationally and the transfer completes at that edge -> IDLE. PSEL=0 in ACCESS before completion aborts: -> IDLE, no write, no pulse.
- Latency: completion occurs WAIT_STATES+1 cycles after the setup cycle. With WAIT_STATES=0, a transfer takes 2 cycles. Back-to-back transfers take WAIT_STATES+2 cycles each; there is no idle cycle requirement.
- PREADY, PRDATA and PSLVERR are nonzero only in the completion cycle; all are 0 otherwise.
- Decode: off = PADDR - BASE_ADDR, modulo 2^ADDR_WIDTH; idx = off >> log2(DATA_WIDTH/8).
  - Error if off is not word-aligned, or off >= REG_COUNT*DATA_WIDTH/8 (this includes PADDR < BASE_ADDR, which wraps to a large off), or the access is a write to a register with RO_MASK[idx]=1.
- Error completion: PSLVERR=1, PRDATA=0, no register change, no wr_pulse. Wait states still apply.
- Write: at the completion edge, for each lane b with PSTRB[b]=1, byte b of register idx takes PWDATA byte b. Lanes with PSTRB[b]=0 are unchanged. PSTRB=0 is a legal, error-free no-op, but wr_pulse[idx] still fires.
- wr_pulse[idx] is registered: high for exactly the one cycle after the commit edge. reg_out shows the new value in that same cycle.
- Read: PRDATA = register idx for RW registers, or the hw_status slice, sampled combinationally in the completion cycle, for RO registers. PSTRB is ignored on reads.
- PADDR, PWRITE, PWDATA and PSTRB are sampled at the completion edge; the master holds them stable through ACCESS per APB.
- RO register storage is never written; its reg_out slice reads 0.
- Reset asserted mid-transfer: immediate return to IDLE, no commit, all outputs to reset values.

Test Plan:
Default params, reset, write 0x0/0x11111111 and 0x1C/0x88888888, read both -> data returned, PSLVERR=0, each transfer 2 cycles, wr_pulse[0] and wr_pulse[7] each high for 1 cycle.
WAIT_STATES=3, write 0x4/0xA5A5A5A5 -> PREADY low for 3 access cycles then high for 1; reg_out slice 1 = 0xA5A5A5A5.
Register 2 = 0xFFFFFFFF, write 0x8/0x12345678 with PSTRB=4'b0101 -> readback 0xFF34FF78; PSTRB=0 write leaves the value unchanged, PSLVERR=0.
RO_MASK=8'h80, hw_status[7]=0xCAFEF00D: read 0x1C -> 0xCAFEF00D; write 0x1C -> PSLVERR=1, no wr_pulse, reg_out slice 7 stays 0.
BASE_ADDR=0x1000: access 0x1020 (out of range), 0x1002 (misaligned), 0x0FFC (below base) -> each PSLVERR=1, PRDATA=0, registers untouched.
Abort and reset: drop PSEL in ACCESS with WAIT_STATES=2 -> no write. Assert PRESETn=0 mid-access -> PREADY=0 immediately, all registers read 0 after release.
